// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// BOOT/RUN/HALT sequencer. Redirects take priority over stalls, which take
// priority over normal advance.
// Optional feature: define FETCH_ALIGN_CHECK_EN to halt with a sticky
// fetch_fault on a misaligned redirect target; otherwise the low two target
// bits are masked off and HALT is never entered.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | one cycle after reset release; PC held, IF/ID bubbled
// RUN   | normal fetch: redirect > stall > advance
// HALT  | misaligned redirect seen; everything frozen until reset
module fetch_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_instr,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_plus4,
    output logic             if_id_valid,
    output logic             fetch_fault,
    output logic [31:0]      fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] instr_nxt, ipc_nxt, ipc4_nxt;
    logic             valid_nxt, fault_nxt;
    logic [31:0]      count_nxt;
    logic [WIDTH-1:0] pc_plus4;

    assign pc_plus4  = pc + WIDTH'(4);
    // PC register feeds memory directly so no input reaches imem_addr
    assign imem_addr = pc;

    // State register; reset wins over every other condition
    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    // Datapath registers: PC, IF/ID and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fetch_fault    <= 1'b0;
            fetch_count    <= 32'd0;
        end else begin
            pc             <= pc_nxt;
            if_id_instr    <= instr_nxt;
            if_id_pc       <= ipc_nxt;
            if_id_pc_plus4 <= ipc4_nxt;
            if_id_valid    <= valid_nxt;
            fetch_fault    <= fault_nxt;
            fetch_count    <= count_nxt;
        end
    end

    // Next-state and next-datapath decode; default is hold everything
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = if_id_instr;
        ipc_nxt   = if_id_pc;
        ipc4_nxt  = if_id_pc_plus4;
        valid_nxt = if_id_valid;
        fault_nxt = fetch_fault;
        count_nxt = fetch_count;
        case (state)
            BOOT: begin
                state_nxt = RUN;
                instr_nxt = NOP_INSTR;
                ipc_nxt   = '0;
                ipc4_nxt  = '0;
                valid_nxt = 1'b0;
            end
            RUN: begin
                if (redirect_valid) begin
                    instr_nxt = NOP_INSTR;
                    ipc_nxt   = '0;
                    ipc4_nxt  = '0;
                    valid_nxt = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (redirect_target[1:0] != 2'b00) begin
                        state_nxt = HALT;
                        fault_nxt = 1'b1;
                    end else begin
                        pc_nxt = redirect_target;
                    end
`else
                    pc_nxt = redirect_target & ~WIDTH'(3);
`endif
                end else if (!stall) begin
                    pc_nxt    = pc_plus4;
                    instr_nxt = imem_instr;
                    ipc_nxt   = pc;
                    ipc4_nxt  = pc_plus4;
                    valid_nxt = 1'b1;
                    count_nxt = fetch_count + 32'd1;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized run,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_target, imem_instr, imem_addr;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;
    logic        if_id_valid, fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;
    int word_mode = 0;

    // model of what the pipeline should hold
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_count;
    logic        m_valid, m_fault, m_booting, m_halted;

    always #5 clk = ~clk;

    fetch_stage #(.WIDTH(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (word_mode == 0) return a;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    always_comb imem_instr = mem_word(imem_addr);

    task automatic bubble();
        m_instr = NOP_INSTR; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
    endtask

    // what one rising edge does, given the inputs currently applied
    task automatic model_edge();
        if (rst) begin
            m_pc = RESET_PC; bubble(); m_fault = 0; m_count = 0;
            m_booting = 1; m_halted = 0;
        end else if (m_booting) begin
            m_booting = 0; bubble();
        end else if (m_halted) begin
        end else if (redirect_valid) begin
            bubble();
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_target % 4 != 0) begin
                m_halted = 1; m_fault = 1;
            end else m_pc = redirect_target;
`else
            m_pc = redirect_target - (redirect_target % 4);
`endif
        end else if (!stall) begin
            m_instr = mem_word(m_pc);
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 4;
            m_valid = 1;
            m_pc    = m_pc + 4;
            m_count = m_count + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", if_id_pc, m_ipc);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_ipc4);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("fetch_count", fetch_count, m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1; stall = 0; redirect_valid = 0; redirect_target = 0;
        tick(); tick();
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", if_id_instr, NOP_INSTR);

        // reset release: imem_addr 0,0,4,8
        rst = 0;
        tick();
        chk("boot_addr", imem_addr, 32'h0);
        chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
        tick();
        chk("first_pc", if_id_pc, 32'h0);
        chk("first_instr", if_id_instr, 32'h0);
        chk("first_addr", imem_addr, 32'h4);
        chk("first_count", fetch_count, 32'd1);
        tick();
        chk("second_addr", imem_addr, 32'h8);
        chk("second_count", fetch_count, 32'd2);
        tick(); tick();
        chk("pre_stall_addr", imem_addr, 32'h10);

        // three stall cycles at 0x10
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h10);
            chk("stall_count", fetch_count, 32'd4);
        end
        stall = 0;
        tick();
        chk("resume_addr", imem_addr, 32'h14);
        chk("resume_pc", if_id_pc, 32'h10);

        // redirect beats stall
        word_mode = 1;
        redirect_valid = 1; redirect_target = 32'h100; stall = 1;
        tick();
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_instr", if_id_instr, NOP_INSTR);
        redirect_valid = 0; stall = 0;
        tick();
        chk("redir_next", imem_addr, 32'h104);
        chk("redir_ifpc", if_id_pc, 32'h100);

        // PC wrap
        redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc_plus4, 32'h0);

        // randomized run
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(99) < 3);
            stall = ($urandom_range(99) < 30);
            redirect_valid = ($urandom_range(99) < 12);
            redirect_target = $urandom;
            if ($urandom_range(99) < 85) redirect_target[1:0] = 2'b00;
            tick();
        end

        // misaligned redirect
        rst = 1; stall = 0; redirect_valid = 0;
        tick();
        rst = 0;
        tick(); tick(); tick();
        redirect_valid = 1; redirect_target = 32'h102;
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_addr", imem_addr, 32'h8);
        redirect_target = 32'h200;
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            tick();
            chk("halt_addr", imem_addr, 32'h8);
        end
`else
        chk("mis_fault", {31'd0, fetch_fault}, 32'd0);
        chk("mis_addr", imem_addr, 32'h100);
`endif

        // reset during stall with pending redirect
        stall = 1; redirect_valid = 1; redirect_target = 32'h200; rst = 1;
        tick();
        chk("rst2_addr", imem_addr, RESET_PC);
        chk("rst2_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst2_count", fetch_count, 32'd0);
        chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
        rst = 0; stall = 0; redirect_valid = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
